// File: rtl/clk_freq_monitor.sv
// Counts meas_clk rising edges over a fixed refclk gate window and
// flags whether the count sits within MIN_COUNT..MAX_COUNT.
module clk_freq_monitor #(
  parameter int GATE_CYCLES   = 50000,
  parameter int SETTLE_CYCLES = 1024,
  parameter int CNT_W         = 16,
  parameter int MIN_COUNT     = 3250,
  parameter int MAX_COUNT     = 3260
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             meas_clk,
  input  logic             pll_locked,
  output logic [CNT_W-1:0] freq_count,
  output logic             count_valid,
  output logic             freq_ok,
  output logic             overflow,
  output logic             meas_active
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETTLE  = 2'd1;
  localparam logic [1:0] MEASURE = 2'd2;

  localparam int GW = $clog2(GATE_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [SW-1:0] SETL_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_COUNT);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);

  logic [1:0]       state;
  logic [2:0]       msync;
  logic [1:0]       lsync;
  logic [GW-1:0]    gate_cnt;
  logic [SW-1:0]    settle_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] edge_next;
  logic             edge_pulse;
  logic             locked;

  assign edge_pulse = msync[1] & ~msync[2];
  assign locked     = lsync[1];

  // Saturating count including this cycle's pulse, so a terminal-cycle
  // edge lands in the window that is closing.
  always_comb begin
    edge_next = edge_cnt;
    if (edge_pulse && edge_cnt != CNT_MAX)
      edge_next = edge_cnt + 1'b1;
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state       <= IDLE;
      msync       <= '0;
      lsync       <= '0;
      gate_cnt    <= '0;
      settle_cnt  <= '0;
      edge_cnt    <= '0;
      freq_count  <= '0;
      count_valid <= 1'b0;
      freq_ok     <= 1'b0;
      overflow    <= 1'b0;
      meas_active <= 1'b0;
    end else begin
      msync       <= {msync[1:0], meas_clk};
      lsync       <= {lsync[0], pll_locked};
      count_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          gate_cnt   <= '0;
          edge_cnt   <= '0;
          settle_cnt <= '0;
          if (locked)
            state <= SETTLE;
        end
        SETTLE: begin
          if (!locked) begin
            state   <= IDLE;
            freq_ok <= 1'b0;
          end else if (settle_cnt == SETL_LAST) begin
            state       <= MEASURE;
            meas_active <= 1'b1;
            gate_cnt    <= '0;
            edge_cnt    <= '0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        MEASURE: begin
          if (!locked) begin
            state       <= IDLE;
            meas_active <= 1'b0;
            freq_ok     <= 1'b0;
            gate_cnt    <= '0;
            edge_cnt    <= '0;
          end else if (gate_cnt == GATE_LAST) begin
            freq_count  <= edge_next;
            overflow    <= (edge_next == CNT_MAX);
            freq_ok     <= (edge_next != CNT_MAX) &&
                           (edge_next >= MIN_C) &&
                           (edge_next <= MAX_C);
            count_valid <= 1'b1;
            gate_cnt    <= '0;
            edge_cnt    <= '0;
          end else begin
            gate_cnt <= gate_cnt + 1'b1;
            edge_cnt <= edge_next;
          end
        end
        default: begin
          state       <= IDLE;
          meas_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/clk_freq_monitor.md
CLK_FREQ_MONITOR -- requirements
Module: clk_freq_monitor

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 50000, measurement window length in refclk cycles (1 ms at 50 MHz).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 1024, refclk cycles to wait after lock before the first window.
REQ-003 SHALL have parameter CNT_W, default 16, width of the edge counter and freq_count.
REQ-004 SHALL have parameter MIN_COUNT, default 3250, lowest in-range edge count per window.
REQ-005 SHALL have parameter MAX_COUNT, default 3260, highest in-range edge count per window.
REQ-006 SHALL have port refclk, input, 1 bit: the single clock (50 MHz reference); all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port meas_clk, input, 1 bit: monitored PLL output clock, asynchronous to refclk, sampled as data only.
REQ-009 SHALL have port pll_locked, input, 1 bit: PLL lock indicator, asynchronous.
REQ-010 SHALL have port freq_count, output, CNT_W bits: rising-edge count of the last completed window.
REQ-011 SHALL have port count_valid, output, 1 bit: one-cycle pulse when freq_count updates.
REQ-012 SHALL have port freq_ok, output, 1 bit: last completed window was within MIN_COUNT..MAX_COUNT with no overflow.
REQ-013 SHALL have port overflow, output, 1 bit: last completed window saturated the counter.
REQ-014 SHALL have port meas_active, output, 1 bit: high while in MEASURE.

Function
REQ-015 SHALL synchronise meas_clk and pll_locked through two refclk flops each before any use.
REQ-016 SHALL detect a meas_clk rising edge as synchronised-now = 1 and previous = 0, using a third flop; the edge pulse occurs 3 refclk cycles after the input edge.
REQ-017 SHALL implement the states IDLE, SETTLE and MEASURE.
REQ-018 IDLE: gate and edge counters held at 0; go to SETTLE when locked_sync = 1.
REQ-019 SETTLE: count SETTLE_CYCLES cycles, then enter MEASURE with gate counter = 0 and edge counter = 0.
REQ-020 MEASURE: gate counter increments each cycle; the edge counter increments on each edge pulse and saturates at 2^CNT_W-1.
REQ-021 An edge pulse in the terminal cycle (gate counter = GATE_CYCLES-1) SHALL be included in the finishing window.
REQ-022 In the terminal cycle the block SHALL register the window results at once:
- freq_count = final count
- overflow = saturation reached
- freq_ok = (MIN_COUNT <= count <= MAX_COUNT) and not saturated
REQ-023 count_valid SHALL be high in the cycle after the terminal cycle, the same cycle the new values become visible.
REQ-024 Windows SHALL run back-to-back: the next window starts in the cycle after the terminal cycle, with no dead cycle and no missed edges.
REQ-025 locked_sync = 0 in SETTLE or MEASURE SHALL, in the next cycle:
- force IDLE
- discard the partial window, with no count_valid
- clear freq_ok
REQ-026 freq_count and overflow SHALL retain their last values after a lock loss.
REQ-027 If lock loss and the terminal cycle coincide, lock loss SHALL win: no update and no count_valid.
REQ-028 meas_active SHALL equal (state == MEASURE), registered.
REQ-029 The block SHALL require meas_clk < refclk/2; behaviour above that is undefined but SHALL not deadlock the state machine.

Reset
REQ-030 rst = 1 SHALL, on the next refclk edge:
- set state to IDLE
- clear all counters and synchronisers
- set freq_count = 0, count_valid = 0, freq_ok = 0, overflow = 0, meas_active = 0
REQ-031 rst asserted mid-MEASURE SHALL abort the window with no count_valid; on release, operation resumes from IDLE.

Verification
REQ-032 Nominal: meas_clk 3.255017 MHz, pll_locked = 1 from the start -> first count_valid about 51027 cycles after rst release; freq_count in {3255, 3256}; freq_ok = 1; overflow = 0; subsequent valids every 50000 cycles.
REQ-033 Out of range: meas_clk 3.300 MHz -> freq_count in {3300, 3301}, freq_ok = 0; meas_clk held at 0 -> freq_count = 0, freq_ok = 0.
REQ-034 Lock loss: drop pll_locked at gate count 20000 -> meas_active low within 4 cycles, freq_ok = 0, no count_valid. Re-assert lock -> valid after SETTLE_CYCLES + GATE_CYCLES.
REQ-035 Saturation: CNT_W = 8, meas_clk 3.255 MHz -> freq_count = 255, overflow = 1, freq_ok = 0.
REQ-036 Boundary: GATE_CYCLES = 10, SETTLE_CYCLES = 2; place an edge pulse in the terminal cycle and one in the first cycle of the next window -> each is counted exactly once, in its own window.
REQ-037 Reset mid-window: assert rst for 1 cycle at gate count 100 -> all outputs 0 next cycle, no count_valid; the next valid arrives a full settle plus window later.
